// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap sequencer for the single-cycle RV32 core.
// Decides at each completing instruction whether to redirect the PC to mtvec or mepc.
module csr_trap_unit #(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        timer_irq,
    input  logic        instr_valid,
    input  logic [31:0] pc,
    input  logic [31:0] next_pc,
    input  logic        ecall,
    input  logic        mret,
    input  logic        csr_en,
    input  logic [1:0]  csr_op,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        trap_taken,
    output logic [31:0] trap_pc,
    output logic        irq_pending
);
    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MIE      = 12'h304;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MIP      = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH  = 12'hB80;
    localparam logic [31:0] ALIGN_MASK    = 32'hFFFF_FFFC;
    localparam logic [31:0] CAUSE_ECALL   = 32'd11;
    localparam logic [31:0] CAUSE_MTI     = 32'h8000_0007;

    logic        mstatus_mie_q, mstatus_mie_d;
    logic        mstatus_mpie_q, mstatus_mpie_d;
    logic        mie_mtie_q, mie_mtie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [63:0] mcycle_q, mcycle_d;

    logic        csr_write;
    logic        ecall_take;
    logic        mret_take;
    logic        int_cond;
    logic        int_take;
    logic [31:0] csr_new;

    // instr_valid qualifies ecall, mret and csr_en; there is no backpressure,
    // every completing instruction is consumed in the cycle it is presented.
    assign csr_write  = instr_valid & csr_en & (csr_op != 2'b00);
    assign ecall_take = instr_valid & ecall;
    assign mret_take  = instr_valid & mret & ~ecall;
    assign int_cond   = instr_valid & mstatus_mie_q & mie_mtie_q & timer_irq;
    assign int_take   = int_cond & ~ecall & ~mret;

    assign trap_taken  = ecall_take | mret_take | int_take;
    assign trap_pc     = mret_take ? mepc_q : mtvec_q;
    assign irq_pending = timer_irq & mie_mtie_q;

    always_comb begin
        csr_rdata = 32'h0;
        case (csr_addr)
            ADDR_MSTATUS:  csr_rdata = {24'h0, mstatus_mpie_q, 3'b000, mstatus_mie_q, 3'b000};
            ADDR_MIE:      csr_rdata = {24'h0, mie_mtie_q, 7'h00};
            ADDR_MTVEC:    csr_rdata = mtvec_q;
            ADDR_MSCRATCH: csr_rdata = mscratch_q;
            ADDR_MEPC:     csr_rdata = mepc_q;
            ADDR_MCAUSE:   csr_rdata = mcause_q;
            ADDR_MIP:      csr_rdata = {24'h0, timer_irq, 7'h00};
            ADDR_MCYCLE:   csr_rdata = mcycle_q[31:0];
            ADDR_MCYCLEH:  csr_rdata = mcycle_q[63:32];
            default:       csr_rdata = 32'h0;
        endcase
    end

    always_comb begin
        case (csr_op)
            2'b10:   csr_new = csr_rdata | csr_wdata;
            2'b11:   csr_new = csr_rdata & ~csr_wdata;
            default: csr_new = csr_wdata;
        endcase
    end

    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_mtie_d     = mie_mtie_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mcycle_d       = mcycle_q + 64'd1;

        if (csr_write) begin
            case (csr_addr)
                ADDR_MSTATUS: begin
                    mstatus_mie_d  = csr_new[3];
                    mstatus_mpie_d = csr_new[7];
                end
                ADDR_MIE:      mie_mtie_d = csr_new[7];
                ADDR_MTVEC:    mtvec_d    = csr_new & ALIGN_MASK;
                ADDR_MSCRATCH: mscratch_d = csr_new;
                ADDR_MEPC:     mepc_d     = csr_new & ALIGN_MASK;
                ADDR_MCAUSE:   mcause_d   = csr_new;
                default: ;
            endcase
        end

        // Trap side effects land after the CSR write so they win on overlap;
        // MIE/MPIE sources are the pre-write register values.
        if (ecall_take) begin
            mepc_d         = pc & ALIGN_MASK;
            mcause_d       = CAUSE_ECALL;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (mret_take) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end else if (int_take) begin
            mepc_d         = next_pc & ALIGN_MASK;
            mcause_d       = CAUSE_MTI;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_mtie_q     <= 1'b0;
            mtvec_q        <= RESET_MTVEC & ALIGN_MASK;
            mscratch_q     <= 32'h0;
            mepc_q         <= 32'h0;
            mcause_q       <= 32'h0;
            mcycle_q       <= 64'h0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_mtie_q     <= mie_mtie_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mcycle_q       <= mcycle_d;
        end
    end
endmodule

// File: doc/csr_trap_unit.md
Name: csr_trap_unit

Overview:
- Machine-mode CSR file and trap sequencer for the single-cycle RV32 core.
- Consumes the timer's level-sensitive interrupt line and decides at instruction boundaries whether to redirect the PC to the trap vector.
- Handles ecall entry and mret return, and exposes csrrw/csrrs/csrrc access to mstatus, mie, mip, mtvec, mepc, mcause, mscratch and mcycle.

Parameters:
- RESET_MTVEC, 32'h0000_0000, mtvec value after reset (bits[1:0] forced 0)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- timer_irq  in  1  level interrupt from timer (high while mtime >= mtimecmp)
- instr_valid  in  1  an instruction completes this cycle
- pc  in  32  PC of the completing instruction
- next_pc  in  32  PC the core would fetch next without a trap
- ecall  in  1  completing instruction is ecall (qualified by instr_valid)
- mret  in  1  completing instruction is mret (qualified by instr_valid)
- csr_en  in  1  completing instruction is a CSR op (qualified by instr_valid)
- csr_op  in  2  01=RW, 10=RS, 11=RC, 00=no write
- csr_addr  in  12  CSR address
- csr_wdata  in  32  rs1 value
- csr_rdata  out  32  old CSR value, combinational
- trap_taken  out  1  redirect PC this cycle, combinational
- trap_pc  out  32  redirect target
- irq_pending  out  1  mip.MTIP & mie.MTIE, ignores mstatus.MIE

Behaviour:
- CSR map:
  - mstatus 0x300: only MIE[3] and MPIE[7] are implemented; other bits read 0.
  - mie 0x304: only MTIE[7] is implemented.
  - mtvec 0x305: direct mode only; bits[1:0] read 0.
  - mscratch 0x340: full 32-bit read/write.
  - mepc 0x341: bits[1:0] read 0.
  - mcause 0x342: full 32-bit read/write.
  - mip 0x344: read-only; MTIP[7] = timer_irq, live; writes are ignored.
  - mcycle 0xB00 / mcycleh 0xB80: read-only here.
  - Unmapped addresses read 0; writes to them are ignored.
- Reset values: all CSRs 0 except mtvec=RESET_MTVEC. mcycle=0.
- Outputs under reset: trap_taken=0 whenever instr_valid=0; trap_pc=mtvec.
- mcycle: 64-bit, +1 every clk, wraps at 2^64 to 0.
- CSR write (csr_en & instr_valid, csr_op!=00), applied at the clk edge:
  - new = RW: wdata; RS: old|wdata; RC: old&~wdata.
  - Unimplemented bits stay 0.
  - csr_rdata always returns the pre-write value.
- Trap conditions, priority high to low:
  1. ecall
  2. mret
  3. interrupt: int_cond = instr_valid & mstatus.MIE & mie.MTIE & timer_irq
- ecall (instr_valid & ecall):
  - trap_taken=1, trap_pc=mtvec.
  - At edge: mepc<=pc, mcause<=32'd11, MPIE<=MIE, MIE<=0.
- mret (instr_valid & mret, no ecall):
  - trap_taken=1, trap_pc=mepc.
  - At edge: MIE<=MPIE, MPIE<=1.
  - A pending interrupt is not taken this cycle; it is evaluated at the next instr_valid.
- Interrupt (int_cond, no ecall/mret):
  - Current instruction completes.
  - trap_taken=1, trap_pc=mtvec.
  - At edge: mepc<=next_pc, mcause<=32'h8000_0007, MPIE<=MIE, MIE<=0.
- Same-cycle CSR write and trap entry:
  - The CSR write applies first; trap-entry updates to mepc, mcause, MIE and MPIE override it.
  - The int_cond decision uses pre-write MIE/MTIE values.
  - Therefore csrrs setting MIE does not trap in the same cycle; it traps on the next completing instruction.
- timer_irq is level-sensitive with no latch:
  - Deassertion before a completing instruction means no trap.
  - It stays pending after entry until software rewrites mtimecmp; MIE=0 prevents re-entry.
- trap_taken and trap_pc are combinational in inputs and current state; zero-cycle latency to the PC mux.
- Async reset mid-operation clears all state immediately; no partial trap is committed.

Test Plan:
- Reset, then read all CSRs → all 0, mtvec=RESET_MTVEC. mcycle reads 5 after 5 clks. Write 0xFFFF_FFFF to mip → reads back 0.
- mscratch: RW 0x1234_5678, then RS 0x0000_0F00, then RC 0x0000_0078. Returns previous value each op; final value 0x1234_5F00.
- timer_irq=1 with MTIE=1, MIE=0 → no trap, irq_pending=1. csrrs mstatus,0x8 → no trap in that cycle. Next instr (pc=0x100, next_pc=0x104), mtvec=0x200 → trap_taken=1, trap_pc=0x200, then mepc=0x104, mcause=0x8000_0007, mstatus=0x80.
- Then mret → trap_pc=0x104, mstatus=0x88. timer_irq still 1 → next instr traps again.
- ecall at pc=0x40 with int_cond true same cycle → trap_pc=mtvec, mepc=0x40, mcause=11.
- Assert rst while timer_irq=1 and MIE=1 → CSRs clear at once, trap_taken=0 on following instructions.
